// File: rtl/clock_pkg.sv
// Types and constants shared by the seconds, minutes and hours stages of the clock chain.
package clock_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t HOUR_MAX_TEN  = 4'd2;
   localparam bcd_t HOUR_MAX_UNIT = 4'd3;
   localparam bcd_t NOON_TEN      = 4'd1;
   localparam bcd_t NOON_UNIT     = 4'd2;

endpackage

// File: rtl/hour_fmt_12h.sv
// Combinational display formatter: 24h BCD count in, 24h or 12h BCD digits plus PM flag out.
module hour_fmt_12h
   import clock_pkg::*;
(
   input  logic [3:0] cnt_ten,
   input  logic [3:0] cnt_unit,
   input  logic       fmt_12h,
   output logic [3:0] disp_ten,
   output logic [3:0] disp_unit,
   output logic       pm
);

   logic is_pm;
   logic is_midnight;
   logic is_noon;

   assign is_pm       = (cnt_ten > NOON_TEN) || ((cnt_ten == NOON_TEN) && (cnt_unit >= NOON_UNIT));
   assign is_midnight = (cnt_ten == 4'd0) && (cnt_unit == 4'd0);
   assign is_noon     = (cnt_ten == NOON_TEN) && (cnt_unit == NOON_UNIT);
   assign pm          = is_pm;

   always_comb begin
      disp_ten  = cnt_ten;
      disp_unit = cnt_unit;
      if (fmt_12h) begin
         if (is_midnight) begin
            disp_ten  = NOON_TEN;
            disp_unit = NOON_UNIT;
         end else if (is_pm && !is_noon) begin
            // Subtract 12 digit-wise: 13-19 borrow only from the unit, 20-23 cross a tens boundary.
            if (cnt_ten == NOON_TEN) begin
               disp_ten  = 4'd0;
               disp_unit = cnt_unit - 4'd2;
            end else if (cnt_unit < 4'd2) begin
               disp_ten  = 4'd0;
               disp_unit = cnt_unit + 4'd8;
            end else begin
               disp_ten  = 4'd1;
               disp_unit = cnt_unit - 4'd2;
            end
         end
      end
   end

endmodule

// File: rtl/counter_hours.sv
// Hours stage: BCD 00-23 count advanced by tick_hour or set-mode up/down, with a registered display stage.
module counter_hours
   import clock_pkg::*;
#(
   parameter bcd_t RESET_TEN  = 4'd0,
   parameter bcd_t RESET_UNIT = 4'd0
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_hour,
   input  logic       up,
   input  logic       down,
   input  logic       tick_hour,
   input  logic       fmt_12h,
   output logic [3:0] hour_unit,
   output logic [3:0] hour_ten,
   output logic       pm,
   output logic       tick_day
);

   bcd_t cnt_ten_reg, cnt_ten_next;
   bcd_t cnt_unit_reg, cnt_unit_next;
   logic day_wrap_reg, day_wrap_next;
   bcd_t hour_ten_reg, hour_unit_reg;
   logic pm_reg, tick_day_reg;

   bcd_t inc_ten, inc_unit, dec_ten, dec_unit;
   bcd_t disp_ten, disp_unit;
   logic disp_pm;
   logic at_max, at_zero, illegal;

   assign at_max  = (cnt_ten_reg == HOUR_MAX_TEN) && (cnt_unit_reg == HOUR_MAX_UNIT);
   assign at_zero = (cnt_ten_reg == 4'd0) && (cnt_unit_reg == 4'd0);
   assign illegal = (cnt_unit_reg > 4'd9) || (cnt_ten_reg > HOUR_MAX_TEN) ||
                    ((cnt_ten_reg == HOUR_MAX_TEN) && (cnt_unit_reg > HOUR_MAX_UNIT));

   always_comb begin
      inc_ten  = cnt_ten_reg;
      inc_unit = cnt_unit_reg + 4'd1;
      if (at_max) begin
         inc_ten  = 4'd0;
         inc_unit = 4'd0;
      end else if (cnt_unit_reg == 4'd9) begin
         inc_ten  = cnt_ten_reg + 4'd1;
         inc_unit = 4'd0;
      end
   end

   always_comb begin
      dec_ten  = cnt_ten_reg;
      dec_unit = cnt_unit_reg - 4'd1;
      if (at_zero) begin
         dec_ten  = HOUR_MAX_TEN;
         dec_unit = HOUR_MAX_UNIT;
      end else if (cnt_unit_reg == 4'd0) begin
         dec_ten  = cnt_ten_reg - 4'd1;
         dec_unit = 4'd9;
      end
   end

   // Only a run-mode rollover reports a day boundary; set-mode wraps are user edits.
   always_comb begin
      cnt_ten_next  = cnt_ten_reg;
      cnt_unit_next = cnt_unit_reg;
      day_wrap_next = 1'b0;
      if (illegal) begin
         cnt_ten_next  = 4'd0;
         cnt_unit_next = 4'd0;
      end else if (mode_hour) begin
         if (tick_hour) begin
            cnt_ten_next  = inc_ten;
            cnt_unit_next = inc_unit;
            day_wrap_next = at_max;
         end
      end else if (up && !down) begin
         cnt_ten_next  = inc_ten;
         cnt_unit_next = inc_unit;
      end else if (down && !up) begin
         cnt_ten_next  = dec_ten;
         cnt_unit_next = dec_unit;
      end
   end

   hour_fmt_12h u_fmt (
      .cnt_ten   (cnt_ten_reg),
      .cnt_unit  (cnt_unit_reg),
      .fmt_12h   (fmt_12h),
      .disp_ten  (disp_ten),
      .disp_unit (disp_unit),
      .pm        (disp_pm)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_ten_reg   <= RESET_TEN;
         cnt_unit_reg  <= RESET_UNIT;
         day_wrap_reg  <= 1'b0;
         hour_ten_reg  <= 4'd0;
         hour_unit_reg <= 4'd0;
         pm_reg        <= 1'b0;
         tick_day_reg  <= 1'b0;
      end else begin
         cnt_ten_reg   <= cnt_ten_next;
         cnt_unit_reg  <= cnt_unit_next;
         day_wrap_reg  <= day_wrap_next;
         hour_ten_reg  <= disp_ten;
         hour_unit_reg <= disp_unit;
         pm_reg        <= disp_pm;
         tick_day_reg  <= day_wrap_reg;
      end
   end

   assign hour_ten  = hour_ten_reg;
   assign hour_unit = hour_unit_reg;
   assign pm        = pm_reg;
   assign tick_day  = tick_day_reg;

endmodule

// File: tb/tb_counter_hours.sv
// Scoreboard bench for counter_hours: an integer-hour model predicts each registered display sample.
module tb_counter_hours;

   logic       clk;
   logic       rst_n;
   logic       mode_hour;
   logic       up;
   logic       down;
   logic       tick_hour;
   logic       fmt_12h;
   logic [3:0] hour_unit;
   logic [3:0] hour_ten;
   logic       pm;
   logic       tick_day;

   typedef struct {
      logic [3:0] ten;
      logic [3:0] unit;
      logic       pm;
      logic       tick;
      int         h;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   model_h;
   logic model_wrap;
   int   n_total;
   int   n_bad;

   counter_hours #(.RESET_TEN(4'd0), .RESET_UNIT(4'd0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_hour (mode_hour),
      .up        (up),
      .down      (down),
      .tick_hour (tick_hour),
      .fmt_12h   (fmt_12h),
      .hour_unit (hour_unit),
      .hour_ten  (hour_ten),
      .pm        (pm),
      .tick_day  (tick_day)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   // Drive one cycle of inputs and push what the display must show after the coming edge.
   task automatic drive(input logic m, input logic u, input logic d, input logic t, input logic f);
      exp_t x;
      int   hh;
      mode_hour = m;
      up        = u;
      down      = d;
      tick_hour = t;
      fmt_12h   = f;
      hh = model_h;
      if (f) hh = (model_h % 12 == 0) ? 12 : model_h % 12;
      x.ten  = 4'(hh / 10);
      x.unit = 4'(hh % 10);
      x.pm   = (model_h >= 12);
      x.tick = model_wrap;
      x.h    = model_h;
      sb_q.push_back(x);
      model_wrap = 1'b0;
      if (m) begin
         if (t) begin
            model_wrap = (model_h == 23);
            model_h = (model_h + 1) % 24;
         end
      end else if (u && !d) begin
         model_h = (model_h + 1) % 24;
      end else if (d && !u) begin
         model_h = (model_h + 23) % 24;
      end
   endtask

   task automatic test_reset();
      mode_hour = 1'b0; up = 1'b0; down = 1'b0; tick_hour = 1'b0; fmt_12h = 1'b0;
      rst_n = 1'b0;
      #13;
      n_total++;
      if ({hour_ten, hour_unit, pm, tick_day} !== 10'b0) begin
         n_bad++;
         $display("FAIL reset_hold: got %h%h pm=%b td=%b want 00 pm=0 td=0", hour_ten, hour_unit, pm, tick_day);
      end else $display("reset_hold: 00 pm=0 td=0");
      @(negedge clk);
      rst_n = 1'b1;
      model_h = 0;
      model_wrap = 1'b0;
      sb_q.delete();
      #1;
      n_total++;
      if ({hour_ten, hour_unit, pm, tick_day} !== 10'b0) begin
         n_bad++;
         $display("FAIL reset_release: got %h%h pm=%b td=%b want 00", hour_ten, hour_unit, pm, tick_day);
      end else $display("reset_release: 00 pm=0 td=0");
      @(posedge clk);
      #1;
   endtask

   task automatic test_run_24();
      for (int i = 0; i < 27; i++) begin
         drive(1'b1, 1'b1, 1'b1, (i < 24) ? 1'b1 : 1'b0, 1'b0);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         n_total++;
         if ({hour_ten, hour_unit, pm, tick_day} !== {e.ten, e.unit, e.pm, e.tick}) begin
            n_bad++;
            $display("FAIL run_24[%0d]: got %h%h pm=%b td=%b want %h%h pm=%b td=%b",
                     i, hour_ten, hour_unit, pm, tick_day, e.ten, e.unit, e.pm, e.tick);
         end else $display("run_24[%0d]: %h%h pm=%b td=%b", i, hour_ten, hour_unit, pm, tick_day);
      end
   endtask

   task automatic test_fmt12_sweep();
      for (int i = 0; i < 25; i++) begin
         drive(1'b0, (i < 24) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         n_total++;
         if ({hour_ten, hour_unit, pm, tick_day} !== {e.ten, e.unit, e.pm, e.tick}) begin
            n_bad++;
            $display("FAIL fmt12[h=%0d]: got %h%h pm=%b td=%b want %h%h pm=%b td=%b",
                     e.h, hour_ten, hour_unit, pm, tick_day, e.ten, e.unit, e.pm, e.tick);
         end else $display("fmt12[h=%0d]: %h%h pm=%b", e.h, hour_ten, hour_unit, pm);
      end
   endtask

   task automatic test_set_wrap();
      for (int i = 0; i < 7; i++) begin
         case (i)
            0:       drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            1:       drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            2, 3, 4: drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         endcase
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         n_total++;
         if ({hour_ten, hour_unit, pm, tick_day} !== {e.ten, e.unit, e.pm, e.tick}) begin
            n_bad++;
            $display("FAIL set_wrap[%0d]: got %h%h pm=%b td=%b want %h%h pm=%b td=%b",
                     i, hour_ten, hour_unit, pm, tick_day, e.ten, e.unit, e.pm, e.tick);
         end else $display("set_wrap[%0d]: %h%h pm=%b td=%b", i, hour_ten, hour_unit, pm, tick_day);
      end
   endtask

   task automatic test_set_20();
      for (int i = 0; i < 24; i++) begin
         if (i < 20)       drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         else if (i == 20) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         else if (i == 21) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         else              drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         n_total++;
         if ({hour_ten, hour_unit, pm, tick_day} !== {e.ten, e.unit, e.pm, e.tick}) begin
            n_bad++;
            $display("FAIL set_20[%0d]: got %h%h pm=%b td=%b want %h%h pm=%b td=%b",
                     i, hour_ten, hour_unit, pm, tick_day, e.ten, e.unit, e.pm, e.tick);
         end else $display("set_20[%0d]: %h%h pm=%b td=%b", i, hour_ten, hour_unit, pm, tick_day);
      end
   endtask

   task automatic test_reset_pending();
      // Count is 19 here; step to 23, tick over midnight, then reset while tick_day is high.
      for (int i = 0; i < 7; i++) begin
         if (i < 4)       drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         else if (i == 5) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         else             drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         n_total++;
         if ({hour_ten, hour_unit, pm, tick_day} !== {e.ten, e.unit, e.pm, e.tick}) begin
            n_bad++;
            $display("FAIL wrap_23[%0d]: got %h%h pm=%b td=%b want %h%h pm=%b td=%b",
                     i, hour_ten, hour_unit, pm, tick_day, e.ten, e.unit, e.pm, e.tick);
         end else $display("wrap_23[%0d]: %h%h pm=%b td=%b", i, hour_ten, hour_unit, pm, tick_day);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({hour_ten, hour_unit, pm, tick_day} !== 10'b0) begin
         n_bad++;
         $display("FAIL reset_pending: got %h%h pm=%b td=%b want 00 td=0", hour_ten, hour_unit, pm, tick_day);
      end else $display("reset_pending: 00 td=0");
      @(negedge clk);
      rst_n = 1'b1;
      mode_hour = 1'b0; up = 1'b0; down = 1'b0; tick_hour = 1'b0;
      model_h = 0;
      model_wrap = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_illegal_fmt();
      mode_hour = 1'b1; up = 1'b0; down = 1'b0; tick_hour = 1'b0; fmt_12h = 1'b0;
      force dut.cnt_ten_reg  = 4'h2;
      force dut.cnt_unit_reg = 4'hA;
      @(posedge clk);
      @(negedge clk);
      release dut.cnt_ten_reg;
      release dut.cnt_unit_reg;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_total++;
         if (tick_day !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_td[%0d]: got td=%b want 0", i, tick_day);
         end else $display("illegal_td[%0d]: td=0", i);
      end
      n_total++;
      if ({hour_ten, hour_unit, pm} !== 9'b0) begin
         n_bad++;
         $display("FAIL illegal_recover: got %h%h pm=%b want 00 pm=0", hour_ten, hour_unit, pm);
      end else $display("illegal_recover: 00 pm=0");
      model_h = 0;
      model_wrap = 1'b0;
      sb_q.delete();
      for (int i = 0; i < 19; i++) begin
         if (i < 15)       drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         else if (i == 15) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         else if (i < 18)  drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         else              drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         @(posedge clk);
         #1;
         e = sb_q.pop_front();
         n_total++;
         if ({hour_ten, hour_unit, pm, tick_day} !== {e.ten, e.unit, e.pm, e.tick}) begin
            n_bad++;
            $display("FAIL fmt_toggle[%0d]: got %h%h pm=%b td=%b want %h%h pm=%b td=%b",
                     i, hour_ten, hour_unit, pm, tick_day, e.ten, e.unit, e.pm, e.tick);
         end else $display("fmt_toggle[%0d]: %h%h pm=%b td=%b", i, hour_ten, hour_unit, pm, tick_day);
      end
   endtask

   initial begin
      n_total = 0;
      n_bad = 0;
      model_h = 0;
      model_wrap = 1'b0;
      rst_n = 1'b1;
      mode_hour = 1'b0; up = 1'b0; down = 1'b0; tick_hour = 1'b0; fmt_12h = 1'b0;
      test_reset();
      test_run_24();
      test_fmt12_sweep();
      test_set_wrap();
      test_set_20();
      test_reset_pending();
      test_illegal_fmt();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
